// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback, drives the datapath and
// memory enables, and keeps a sticky illegal-opcode flag plus a counter of
// retired instructions. Outputs decode from the state register only, except
// IRWrite/PCWrite in FETCH, which wait for MemReady.
module multicycle_control #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       Op,
   input  logic             MemReady,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic [3:0]       State,
   output logic             IllegalOp,
   output logic [CNT_W-1:0] InstrCount
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      FETCH   = 4'd1,
      DECODE  = 4'd2,
      MEMADDR = 4'd3,
      MEMRD   = 4'd4,
      MEMWB   = 4'd5,
      MEMWR   = 4'd6,
      EXEC    = 4'd7,
      RWB     = 4'd8,
      BRANCH  = 4'd9,
      JUMP    = 4'd10,
      ADDIEX  = 4'd11,
      ADDIWB  = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   state_t           state_r;
   state_t           next_s;
   logic             retire_s;
   logic             illegal_s;
   logic             illegal_r;
   logic [CNT_W-1:0] count_r;

   // State register; reset drops straight back to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state selection plus retire / illegal-opcode events for this edge.
   always_comb begin
      next_s    = state_r;
      retire_s  = 1'b0;
      illegal_s = 1'b0;
      case (state_r)
         IDLE:    next_s = FETCH;
         FETCH: begin
            if (MemReady) begin
               next_s = DECODE;
            end else begin
               next_s = FETCH;
            end
         end
         DECODE: begin
            case (Op)
               OP_LW, OP_SW: next_s = MEMADDR;
               OP_RTYPE:     next_s = EXEC;
               OP_BEQ:       next_s = BRANCH;
               OP_J:         next_s = JUMP;
               OP_ADDI:      next_s = ADDIEX;
               default: begin
                  next_s    = FETCH;
                  illegal_s = 1'b1;
               end
            endcase
         end
         MEMADDR: begin
            // IR is stable here, so Op still names the lw/sw just decoded.
            if (Op == OP_LW) begin
               next_s = MEMRD;
            end else if (Op == OP_SW) begin
               next_s = MEMWR;
            end else begin
               next_s = FETCH;
            end
         end
         MEMRD: begin
            if (MemReady) begin
               next_s = MEMWB;
            end else begin
               next_s = MEMRD;
            end
         end
         MEMWB: begin
            next_s   = FETCH;
            retire_s = 1'b1;
         end
         MEMWR: begin
            if (MemReady) begin
               next_s   = FETCH;
               retire_s = 1'b1;
            end else begin
               next_s = MEMWR;
            end
         end
         EXEC:    next_s = RWB;
         RWB: begin
            next_s   = FETCH;
            retire_s = 1'b1;
         end
         BRANCH: begin
            next_s   = FETCH;
            retire_s = 1'b1;
         end
         JUMP: begin
            next_s   = FETCH;
            retire_s = 1'b1;
         end
         ADDIEX:  next_s = ADDIWB;
         ADDIWB: begin
            next_s   = FETCH;
            retire_s = 1'b1;
         end
         default: next_s = FETCH;
      endcase
   end

   // Sticky illegal flag and wrapping retired-instruction counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_r <= 1'b0;
         count_r   <= {CNT_W{1'b0}};
      end else begin
         illegal_r <= illegal_r | illegal_s;
         if (retire_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            count_r <= count_r;
         end
      end
   end

   // Moore control decode; only the FETCH IR/PC loads look at MemReady.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      case (state_r)
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = MemReady;
            PCWrite = MemReady;
         end
         DECODE:  ALUSrcB = 2'b11;
         MEMADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         RWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
         end
         JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
         end
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         ADDIWB:  RegWrite = 1'b1;
         default: PCWrite = 1'b0;
      endcase
   end

   assign State      = state_r;
   assign IllegalOp  = illegal_r;
   assign InstrCount = count_r;

endmodule
